// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU-port controller: display-mode encodings,
// register indices, status-byte bit positions and the port sequencer states.
package vdp_pkg;

    typedef enum logic [1:0] {
        MODE_TEXT = 2'd0,
        MODE_G1   = 2'd1,
        MODE_G2   = 2'd2,
        MODE_MC   = 2'd3
    } vdp_mode_e;

    localparam logic [2:0] REG_R0 = 3'd0;
    localparam logic [2:0] REG_R1 = 3'd1;
    localparam logic [2:0] REG_R2 = 3'd2;
    localparam logic [2:0] REG_R3 = 3'd3;
    localparam logic [2:0] REG_R4 = 3'd4;
    localparam logic [2:0] REG_R5 = 3'd5;
    localparam logic [2:0] REG_R6 = 3'd6;
    localparam logic [2:0] REG_R7 = 3'd7;

    localparam int unsigned STAT_F  = 7;
    localparam int unsigned STAT_5S = 6;
    localparam int unsigned STAT_C  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR
    } port_state_e;

    // Text mode (M1) overrides everything, then Graphics II (M3), then multicolor (M2).
    function automatic vdp_mode_e decode_mode(input logic [7:0] r0, input logic [7:0] r1);
        if (r1[4])      return MODE_TEXT;
        else if (r0[1]) return MODE_G2;
        else if (r1[3]) return MODE_MC;
        else            return MODE_G1;
    endfunction

endpackage

// File: rtl/vdp_reg_file.sv
// VDP registers R0-R7 and their combinational decode into video-block config.
module vdp_reg_file
    import vdp_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [7:0]  wr_data,
    output logic [1:0]  mode,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] font_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr,
    output logic        video_on,
    output logic        vert_retrace_int,
    output logic        sprite_large,
    output logic        sprite_enlarged,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color
);

    logic [7:0] r_r0, r_r1, r_r2, r_r3, r_r4, r_r5, r_r6, r_r7;
    vdp_mode_e  w_mode;
    logic       w_unused_bits;

    // Register storage; a write lands on the clock edge that accepts it.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_r0 <= '0; r_r1 <= '0; r_r2 <= '0; r_r3 <= '0;
            r_r4 <= '0; r_r5 <= '0; r_r6 <= '0; r_r7 <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                REG_R0:  r_r0 <= wr_data;
                REG_R1:  r_r1 <= wr_data;
                REG_R2:  r_r2 <= wr_data;
                REG_R3:  r_r3 <= wr_data;
                REG_R4:  r_r4 <= wr_data;
                REG_R5:  r_r5 <= wr_data;
                REG_R6:  r_r6 <= wr_data;
                REG_R7:  r_r7 <= wr_data;
                default: ;
            endcase
        end
    end

    // Table base addresses and flags; G-II uses coarser color/pattern bases.
    always_comb begin
        w_mode                    = decode_mode(r_r0, r_r1);
        mode                      = w_mode;
        name_table_addr           = {r_r2[3:0], 10'b0};
        color_table_addr          = (w_mode == MODE_G2) ? {r_r3[7], 13'b0} : {r_r3, 6'b0};
        font_addr                 = (w_mode == MODE_G2) ? {r_r4[2], 13'b0} : {r_r4[2:0], 11'b0};
        sprite_attr_addr          = {r_r5[6:0], 7'b0};
        sprite_pattern_table_addr = {r_r6[2:0], 11'b0};
        video_on                  = r_r1[6];
        vert_retrace_int          = r_r1[5];
        sprite_large              = r_r1[1];
        sprite_enlarged           = r_r1[0];
        text_color                = r_r7[7:4];
        back_color                = r_r7[3:0];
    end

    assign w_unused_bits = ^{r_r0[7:2], r_r0[0], r_r1[7], r_r1[2],
                             r_r2[7:4], r_r4[7:3], r_r5[7], r_r6[7:3]};

endmodule

// File: rtl/vdp_port_ctrl.sv
// CPU-side VDP port controller: control/data port decode, VRAM access
// sequencing with read-ahead buffer, address counter and status register.
// Build option VDP_WRITE_THROUGH_BUF_EN: data-port writes also load the
// read-ahead buffer (silicon behaviour); otherwise only prefetches update it.
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              port_sel,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    input  logic              frame_pulse,
    input  logic              collision_in,
    input  logic              fifth_in,
    input  logic [4:0]        fifth_num,
    output logic [1:0]        mode,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pattern_table_addr,
    output logic              video_on,
    output logic              vert_retrace_int,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    output logic              n_int
);

    port_state_e       r_state;
    logic [7:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_wr, r_vram_rd;
    logic [7:0]        r_vram_wdata;
    logic [7:0]        r_lo;
    logic              r_latch;
    logic [7:0]        r_rd_buf;
    logic [7:0]        r_cpu_dout;
    logic              r_f, r_5s, r_c;
    logic [4:0]        r_fifth_num;
    logic              r_fifth_d;

    logic              w_idle;
    logic              w_ctrl_rd_acc;
    logic              w_reg_wr;
    logic [ADDR_W-1:0] w_new_addr;
    logic [7:0]        w_status;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_ctrl_rd_acc = w_idle && cpu_rd && port_sel;
    assign w_reg_wr      = w_idle && cpu_wr && port_sel && r_latch && cpu_din[7];
    assign w_new_addr    = ADDR_W'({cpu_din[5:0], r_lo});

    // Status byte as presented on a control-port read.
    always_comb begin
        w_status          = '0;
        w_status[STAT_F]  = r_f;
        w_status[STAT_5S] = r_5s;
        w_status[STAT_C]  = r_c;
        w_status[4:0]     = r_fifth_num;
    end

    // Port sequencer: accepts CPU strobes only when idle, drives one-cycle VRAM strobes.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_addr       <= '0;
            r_vram_addr  <= '0;
            r_vram_wr    <= 1'b0;
            r_vram_rd    <= 1'b0;
            r_vram_wdata <= '0;
            r_lo         <= '0;
            r_latch      <= 1'b0;
            r_rd_buf     <= '0;
            r_cpu_dout   <= '0;
        end else begin
            r_vram_wr <= 1'b0;
            r_vram_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_wr && port_sel) begin
                        if (!r_latch) begin
                            r_lo    <= cpu_din;
                            r_latch <= 1'b1;
                        end else begin
                            r_latch <= 1'b0;
                            if (!cpu_din[7]) begin
                                if (cpu_din[6]) begin
                                    r_addr <= w_new_addr;
                                end else begin
                                    r_vram_addr <= w_new_addr;
                                    r_addr      <= w_new_addr + ADDR_W'(1);
                                    r_vram_rd   <= 1'b1;
                                    r_state     <= ST_RD;
                                end
                            end
                        end
                    end else if (cpu_wr) begin
                        r_vram_addr  <= r_addr;
                        r_vram_wdata <= cpu_din;
                        r_vram_wr    <= 1'b1;
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_latch      <= 1'b0;
                        r_state      <= ST_WR;
`ifdef VDP_WRITE_THROUGH_BUF_EN
                        r_rd_buf     <= cpu_din;
`endif
                    end else if (cpu_rd && port_sel) begin
                        r_cpu_dout <= w_status;
                        r_latch    <= 1'b0;
                    end else if (cpu_rd) begin
                        r_cpu_dout  <= r_rd_buf;
                        r_vram_addr <= r_addr;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_vram_rd   <= 1'b1;
                        r_latch     <= 1'b0;
                        r_state     <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 8'(RD_LAT - 1)) begin
                        r_rd_buf <= vram_rdata;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_WR: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Status flags: set events take priority over the clear caused by a status read.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_f         <= 1'b0;
            r_c         <= 1'b0;
            r_5s        <= 1'b0;
            r_fifth_num <= '0;
            r_fifth_d   <= 1'b0;
        end else begin
            r_fifth_d <= fifth_in;
            r_f       <= frame_pulse  | (r_f & ~w_ctrl_rd_acc);
            r_c       <= collision_in | (r_c & ~w_ctrl_rd_acc);
            if (fifth_in && !r_fifth_d && !r_5s) begin
                r_5s        <= 1'b1;
                r_fifth_num <= fifth_num;
            end else if (w_ctrl_rd_acc) begin
                r_5s <= 1'b0;
            end
        end
    end

    vdp_reg_file u_regs (
        .clk                       (clk),
        .n_reset                   (n_reset),
        .wr_en                     (w_reg_wr),
        .wr_idx                    (cpu_din[2:0]),
        .wr_data                   (r_lo),
        .mode                      (mode),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr),
        .video_on                  (video_on),
        .vert_retrace_int          (vert_retrace_int),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .text_color                (text_color),
        .back_color                (back_color)
    );

    assign cpu_dout   = r_cpu_dout;
    assign busy       = !w_idle;
    assign vram_addr  = r_vram_addr;
    assign vram_wr    = r_vram_wr;
    assign vram_rd    = r_vram_rd;
    assign vram_wdata = r_vram_wdata;
    assign n_int      = ~(r_f & vert_retrace_int);

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Self-checking bench for vdp_port_ctrl against a transaction-level VDP model.
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        port_sel = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [13:0] vram_addr;
    logic        vram_wr, vram_rd;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = '0;
    logic        frame_pulse = 1'b0, collision_in = 1'b0, fifth_in = 1'b0;
    logic [4:0]  fifth_num = '0;
    logic [1:0]  mode;
    logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
    logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged, n_int;
    logic [3:0]  text_color, back_color;

    always #5 clk = ~clk;

    vdp_port_ctrl #(.ADDR_W(14), .RD_LAT(1)) dut (
        .clk(clk), .n_reset(n_reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy), .vram_addr(vram_addr),
        .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .frame_pulse(frame_pulse), .collision_in(collision_in), .fifth_in(fifth_in),
        .fifth_num(fifth_num), .mode(mode), .name_table_addr(name_table_addr),
        .color_table_addr(color_table_addr), .font_addr(font_addr),
        .sprite_attr_addr(sprite_attr_addr), .sprite_pattern_table_addr(sprite_pattern_table_addr),
        .video_on(video_on), .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
        .sprite_enlarged(sprite_enlarged), .text_color(text_color), .back_color(back_color),
        .n_int(n_int)
    );

    // VRAM: unwritten locations read back a fixed address-derived pattern.
    logic [7:0]  vram [16384];
    bit          vram_ok [16384];
    int          wr_count = 0, rd_count = 0;
    logic [13:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [7:0]  last_wr_data = '0;

    function automatic logic [7:0] fill_pat(input int unsigned a);
        return 8'((a * 37) ^ (a >> 6));
    endfunction

    always @(posedge clk) begin
        if (vram_wr) begin
            vram[vram_addr] = vram_wdata;
            vram_ok[vram_addr] = 1'b1;
            wr_count = wr_count + 1;
            last_wr_addr = vram_addr;
            last_wr_data = vram_wdata;
        end
        if (vram_rd) begin
            vram_rdata <= vram_ok[vram_addr] ? vram[vram_addr] : fill_pat(vram_addr);
            rd_count = rd_count + 1;
            last_rd_addr = vram_addr;
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [16384];
    bit          ref_ok [16384];
    logic [7:0]  m_reg [8];
    int unsigned m_addr;
    logic        m_latch;
    logic [7:0]  m_lo, m_buf;
    logic        m_f, m_5s, m_c;
    logic [4:0]  m_fnum;
    int          errors = 0, checks = 0;

    function automatic logic [7:0] ref_rd(input int unsigned a);
        return ref_ok[a] ? ref_mem[a] : fill_pat(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_addr = 0; m_latch = 0; m_lo = '0; m_buf = '0;
        m_f = 0; m_5s = 0; m_c = 0; m_fnum = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_timeout: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic strobe(input logic is_wr, input logic port, input logic [7:0] d);
        @(negedge clk);
        port_sel = port; cpu_din = d; cpu_wr = is_wr; cpu_rd = !is_wr;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        strobe(1'b1, 1'b1, d);
        wait_idle("ctrl_wr");
        if (!m_latch) begin
            m_lo = d; m_latch = 1;
        end else begin
            m_latch = 0;
            if (d[7]) m_reg[d[2:0]] = m_lo;
            else begin
                m_addr = {d[5:0], m_lo};
                if (!d[6]) begin
                    m_buf = ref_rd(m_addr);
                    m_addr = (m_addr + 1) % 16384;
                end
            end
        end
    endtask

    task automatic data_wr(input logic [7:0] d);
        int c0 = wr_count;
        int unsigned ea = m_addr;
        strobe(1'b1, 1'b0, d);
        wait_idle("data_wr");
        ref_mem[ea] = d; ref_ok[ea] = 1'b1;
`ifdef VDP_WRITE_THROUGH_BUF_EN
        m_buf = d;
`endif
        m_addr = (m_addr + 1) % 16384; m_latch = 0;
        checks++;
        if (wr_count !== c0 + 1 || last_wr_addr !== 14'(ea) || last_wr_data !== d) begin
            errors++;
            $display("FAIL data_wr: writes=%0d addr=%h data=%h required writes=%0d addr=%h data=%h",
                     wr_count - c0, last_wr_addr, last_wr_data, 1, ea, d);
        end
    endtask

    task automatic data_rd(output logic [7:0] got);
        logic [7:0] exp = m_buf;
        int unsigned ea = m_addr;
        strobe(1'b0, 1'b0, 8'h00);
        got = cpu_dout;
        wait_idle("data_rd");
        m_buf = ref_rd(ea); m_addr = (m_addr + 1) % 16384; m_latch = 0;
        checks++;
        if (got !== exp || last_rd_addr !== 14'(ea)) begin
            errors++;
            $display("FAIL data_rd: dout=%h fetch_addr=%h required dout=%h fetch_addr=%h",
                     got, last_rd_addr, exp, ea);
        end
    endtask

    task automatic ctrl_rd(output logic [7:0] got);
        logic [7:0] exp = {m_f, m_5s, m_c, m_fnum};
        strobe(1'b0, 1'b1, 8'h00);
        got = cpu_dout;
        wait_idle("ctrl_rd");
        m_f = 0; m_5s = 0; m_c = collision_in; m_latch = 0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ctrl_rd status: got=%h required=%h", got, exp);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_pulse = 1'b1;
        @(negedge clk); frame_pulse = 1'b0;
        m_f = 1;
    endtask

    task automatic raise_fifth(input logic [4:0] n);
        @(negedge clk); fifth_num = n; fifth_in = 1'b1;
        @(negedge clk); fifth_in = 1'b0;
        if (!m_5s) begin m_5s = 1; m_fnum = n; end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0]  r0 = m_reg[0], r1 = m_reg[1];
        logic [1:0]  em;
        int unsigned nt, ct, ft, sa, sp;
        logic [13:0] g_nt, g_ct, g_ft, g_sa, g_sp;
        logic [11:0] em_misc;
        if (r1 & 8'd16)     em = 2'd0;
        else if (r0 & 8'd2) em = 2'd2;
        else if (r1 & 8'd8) em = 2'd3;
        else                em = 2'd1;
        nt = (m_reg[2] % 16) * 1024;
        ct = (em == 2) ? (m_reg[3] / 128) * 8192 : m_reg[3] * 64;
        ft = (em == 2) ? ((m_reg[4] / 4) % 2) * 8192 : (m_reg[4] % 8) * 2048;
        sa = (m_reg[5] % 128) * 128;
        sp = (m_reg[6] % 8) * 2048;
        g_nt = name_table_addr; g_ct = color_table_addr; g_ft = font_addr;
        g_sa = sprite_attr_addr; g_sp = sprite_pattern_table_addr;
        em_misc = {r1[6], r1[5], r1[1], r1[0], 4'(m_reg[7] / 16), 4'(m_reg[7] % 16)};
        checks++;
        if (mode !== em) begin
            errors++;
            $display("FAIL %s mode: got=%0d required=%0d", tag, mode, em);
        end
        checks++;
        if (g_nt !== 14'(nt) || g_ct !== 14'(ct) || g_ft !== 14'(ft) || g_sa !== 14'(sa) || g_sp !== 14'(sp)) begin
            errors++;
            $display("FAIL %s tables: got=%h %h %h %h %h required=%h %h %h %h %h",
                     tag, g_nt, g_ct, g_ft, g_sa, g_sp, nt, ct, ft, sa, sp);
        end
        checks++;
        if ({video_on, vert_retrace_int, sprite_large, sprite_enlarged, text_color, back_color} !== em_misc) begin
            errors++;
            $display("FAIL %s flags_colors: got=%h required=%h", tag,
                     {video_on, vert_retrace_int, sprite_large, sprite_enlarged, text_color, back_color}, em_misc);
        end
        checks++;
        if (n_int !== !(m_f && r1[5])) begin
            errors++;
            $display("FAIL %s n_int: got=%b required=%b", tag, n_int, !(m_f && r1[5]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk); n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cpu_dout, busy, vram_wr, vram_rd, n_int} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: dout=%h busy=%b wr=%b rd=%b n_int=%b required 00 0 0 0 1",
                     cpu_dout, busy, vram_wr, vram_rd, n_int);
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL reset_mode: got=%0d required=1", mode);
        end
        check_outputs("reset");
    endtask

    task automatic test_reg_write();
        ctrl_wr(8'hF0); ctrl_wr(8'h87);
        checks++;
        if (text_color !== 4'hF || back_color !== 4'h0) begin
            errors++;
            $display("FAIL reg_r7: text=%h back=%h required F 0", text_color, back_color);
        end
        check_outputs("reg_write");
        data_wr(8'h77);
    endtask

    task automatic test_data_write();
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'hAA); data_wr(8'h55);
        checks++;
        if (vram[0] !== 8'hAA || vram[1] !== 8'h55) begin
            errors++;
            $display("FAIL vram_contents: [0]=%h [1]=%h required AA 55", vram[0], vram[1]);
        end
        data_wr(8'h3C);
        checks++;
        if (last_wr_addr !== 14'd2) begin
            errors++;
            $display("FAIL addr_after_two_writes: got=%h required=0002", last_wr_addr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] g0, g1;
        ctrl_wr(8'hFF); ctrl_wr(8'h7F);
        data_wr(8'h12); data_wr(8'h34);
        ctrl_wr(8'hFF); ctrl_wr(8'h3F);
        data_rd(g0); data_rd(g1);
        checks++;
        if (g0 !== 8'h12 || g1 !== 8'h34) begin
            errors++;
            $display("FAIL wrap_reads: got=%h %h required=12 34", g0, g1);
        end
    endtask

    task automatic test_interrupt();
        logic [7:0] s;
        ctrl_wr(8'h20); ctrl_wr(8'h81);
        pulse_frame();
        checks++;
        if (n_int !== 1'b0) begin
            errors++;
            $display("FAIL int_assert: n_int=%b required 0", n_int);
        end
        ctrl_rd(s);
        checks++;
        if (s[7] !== 1'b1 || n_int !== 1'b1) begin
            errors++;
            $display("FAIL int_ack: bit7=%b n_int=%b required 1 1", s[7], n_int);
        end
        ctrl_rd(s);
        check_outputs("interrupt");
    endtask

    task automatic test_status();
        logic [7:0] s;
        @(negedge clk); collision_in = 1'b1; fifth_num = 5'h13; fifth_in = 1'b1;
        @(negedge clk);
        m_c = 1; if (!m_5s) begin m_5s = 1; m_fnum = 5'h13; end
        ctrl_rd(s);
        ctrl_rd(s);
        @(negedge clk); collision_in = 1'b0;
        ctrl_rd(s);
        ctrl_rd(s);
        checks++;
        if (s !== 8'h13) begin
            errors++;
            $display("FAIL status_cleared: got=%h required=13", s);
        end
        @(negedge clk); fifth_in = 1'b0;
        raise_fifth(5'h07);
        raise_fifth(5'h1F);
        ctrl_rd(s);
    endtask

    task automatic test_latch();
        logic [7:0] g;
        ctrl_wr(8'h05);
        data_rd(g);
        ctrl_wr(8'h3C); ctrl_wr(8'h87);
        checks++;
        if (text_color !== 4'h3 || back_color !== 4'hC) begin
            errors++;
            $display("FAIL latch_clear: text=%h back=%h required 3 C", text_color, back_color);
        end
        check_outputs("latch");
    endtask

    task automatic test_busy_drop();
        int c0, r0;
        logic [7:0] g;
        ctrl_wr(8'h00); ctrl_wr(8'h41);
        c0 = wr_count;
        @(negedge clk); port_sel = 1'b0; cpu_din = 8'hA1; cpu_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_write: busy=%b required 1", busy);
        end
        cpu_din = 8'hB2;
        @(negedge clk); cpu_wr = 1'b0;
        wait_idle("busy_drop");
        ref_mem[m_addr] = 8'hA1; ref_ok[m_addr] = 1'b1;
`ifdef VDP_WRITE_THROUGH_BUF_EN
        m_buf = 8'hA1;
`endif
        m_addr = (m_addr + 1) % 16384; m_latch = 0;
        checks++;
        if (wr_count !== c0 + 1 || last_wr_data !== 8'hA1 || last_wr_addr !== 14'h0100) begin
            errors++;
            $display("FAIL busy_drop_write: writes=%0d data=%h addr=%h required 1 A1 0100",
                     wr_count - c0, last_wr_data, last_wr_addr);
        end
        // control strobe landing while a prefetch is in flight must be ignored
        r0 = rd_count;
        @(negedge clk); port_sel = 1'b0; cpu_rd = 1'b1;
        @(negedge clk); cpu_rd = 1'b0; port_sel = 1'b1; cpu_din = 8'h9F; cpu_wr = 1'b1;
        @(negedge clk); cpu_wr = 1'b0;
        wait_idle("busy_drop_rd");
        m_buf = ref_rd(m_addr); m_addr = (m_addr + 1) % 16384; m_latch = 0;
        checks++;
        if (rd_count !== r0 + 1) begin
            errors++;
            $display("FAIL busy_drop_read: fetches=%0d required 1", rd_count - r0);
        end
        data_wr(8'hC3);
        data_rd(g);
        check_outputs("busy_drop");
    endtask

    task automatic test_write_buf();
        logic [7:0] g;
        ctrl_wr(8'h10); ctrl_wr(8'h40);
        data_wr(8'h5A);
        data_rd(g);
    endtask

    task automatic test_decode();
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 8; r++) begin
                logic [7:0] v = 8'($urandom);
                if (r == 1) v = {v[7:5], it[1:0] == 2'd0, it[1:0] == 2'd1, v[2:0]};
                if (r == 0) v[1] = it[2];
                ctrl_wr(v);
                ctrl_wr(8'h80 | 8'(r));
            end
            check_outputs("decode");
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk); port_sel = 1'b0; cpu_rd = 1'b1;
        @(negedge clk); cpu_rd = 1'b0; n_reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, vram_rd, vram_wr, cpu_dout} !== 11'h000) begin
            errors++;
            $display("FAIL reset_midop: busy=%b rd=%b wr=%b dout=%h required 0 0 0 00",
                     busy, vram_rd, vram_wr, cpu_dout);
        end
        n_reset = 1'b1;
        model_reset();
        check_outputs("reset_midop");
    endtask

    task automatic test_random();
        logic [7:0] g;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ctrl_wr(8'($urandom));
                2:       data_wr(8'($urandom));
                3:       data_rd(g);
                4:       ctrl_rd(g);
                default: pulse_frame();
            endcase
        end
        check_outputs("random");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish required finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_reg_write();
        test_data_write();
        test_wrap();
        test_interrupt();
        test_status();
        test_latch();
        test_busy_drop();
        test_write_buf();
        test_decode();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
